// File: rtl/alu_ctl_md.sv
// ALU control with a multi-cycle multiply/divide sequencer for the EX stage.
//
// Decodes the main-decoder class and the R-type function field into a 4-bit ALU
// operation code. A shift-add multiplier and a restoring divider share one set of
// registers, take one step per cycle, and own the HI/LO result registers.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   valid_i          EX instruction valid and not being flushed
//   alu_op_i         main-decoder class (00 add, 01 sub, 10 R-type, 11 or)
//   funct_i          instruction function field
//   a_i, b_i         rs / rt operands
//   alu_operation_o  ALU operation code (combinational)
//   hi_lo_sel_o      EX result comes from hi_lo_out_o (mfhi/mflo)
//   hi_lo_out_o      HI for mfhi, LO for mflo, else 0
//   md_stall_o       hold IF/ID/EX this cycle
//   md_busy_o        sequencer not idle (registered)
module alu_ctl_md #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [3:0]       alu_operation_o,
  output logic             hi_lo_sel_o,
  output logic [WIDTH-1:0] hi_lo_out_o,
  output logic             md_stall_o,
  output logic             md_busy_o
);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;          // negate product / quotient in FIX
  logic                 neg_rem_q, neg_rem_d;  // dividend sign, applied to remainder
  logic [WIDTH-1:0]     a_q, a_d;              // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]     b_q, b_d;              // multiplier (shifts right), or divisor
  logic [2*WIDTH-1:0]   acc_q, acc_d;          // product, or remainder in the upper half
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // ALU operation decode
  always_comb begin
    alu_operation_o = 4'b0000;
    unique case (alu_op_i)
      2'b00: alu_operation_o = 4'b0010;
      2'b01: alu_operation_o = 4'b0110;
      2'b11: alu_operation_o = 4'b0001;
      2'b10: begin
        case (funct_i)
          6'd32, 6'd33: alu_operation_o = 4'b0010;
          6'd34, 6'd35: alu_operation_o = 4'b0110;
          6'd36:        alu_operation_o = 4'b0000;
          6'd37:        alu_operation_o = 4'b0001;
          6'd38:        alu_operation_o = 4'b0011;
          6'd39:        alu_operation_o = 4'b1100;
          6'd42:        alu_operation_o = 4'b0111;
          6'd43:        alu_operation_o = 4'b1111;
          6'd0:         alu_operation_o = 4'b1000;
          6'd2:         alu_operation_o = 4'b1001;
          6'd3:         alu_operation_o = 4'b1010;
          default:      alu_operation_o = 4'b0000;
        endcase
      end
      default: alu_operation_o = 4'b0000;
    endcase
  end

  // Request/read qualification. Funct 24..27 share the upper bits 0110;
  // bit 0 selects unsigned, bit 1 selects divide.
  logic is_rtype, md_req, md_read, idle, accept;
  assign is_rtype = (alu_op_i == 2'b10);
  assign md_req   = valid_i & is_rtype & (funct_i[5:2] == 4'b0110);
  assign md_read  = valid_i & is_rtype & ((funct_i == 6'd16) | (funct_i == 6'd18));
  assign idle     = (state_q == StIdle);
  assign accept   = md_req & idle;

  assign md_stall_o  = (md_req | md_read) & ~idle;
  assign md_busy_o   = ~idle;
  assign hi_lo_sel_o = md_read;
  assign hi_lo_out_o = !md_read ? '0 : (funct_i[1] ? lo_q : hi_q);

  // Operand conditioning at accept
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sgn   = ~funct_i[0];
  assign sa    = sgn & a_i[WIDTH-1];
  assign sb    = sgn & b_i[WIDTH-1];
  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;

  // One multiply step: add multiplicand into the upper half, shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};

  // One restoring-divide step: shift next dividend bit into the remainder
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   trial, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign trial    = {rem, a_q[WIDTH-1]};
  assign diff     = trial - {1'b0, b_q};
  assign q_bit    = (trial >= {1'b0, b_q});
  assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

  // Sign fix-up
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -a_q : a_q;
  assign rem_fix  = neg_rem_q ? -rem : rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StIter;
          a_d       = mag_a;
          b_d       = mag_b;
          is_div_d  = funct_i[1];
          // Divide by zero keeps an all-ones quotient regardless of signs
          neg_d     = (sa ^ sb) & (~funct_i[1] | (b_i != '0));
          neg_rem_d = sa;
          acc_d     = '0;
          cnt_d     = '0;
        end
      end
      StIter: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = {rem_next, acc_q[WIDTH-1:0]};
          a_d   = {a_q[WIDTH-2:0], q_bit};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule
